// File: rtl/sd_cmd_engine_if.sv
// rtl/sd_cmd_engine_if.sv - register-block side of the SD CMD-line engine
interface sd_cmd_engine_if;
  logic         new_command;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic [1:0]   resp_type;
  logic         cmd_busy;
  logic         cmd_complete;
  logic         cmd_index_error;
  logic         cmd_crc_error;
  logic         cmd_timeout_error;
  logic [127:0] response;

  modport master (
    output new_command, cmd_index, cmd_argument, resp_type,
    input  cmd_busy, cmd_complete, cmd_index_error, cmd_crc_error,
           cmd_timeout_error, response
  );

  modport slave (
    input  new_command, cmd_index, cmd_argument, resp_type,
    output cmd_busy, cmd_complete, cmd_index_error, cmd_crc_error,
           cmd_timeout_error, response
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD CMD-line engine: CRC7 command serialiser, response capture and check
module sd_cmd_engine #(
  parameter int DIV_W        = 8,
  parameter int TIMEOUT_BITS = 64,
  parameter int TO_W         = 7
) (
  input  logic             clk_host,
  input  logic             reset_host,
  input  logic [DIV_W-1:0] clk_div,
  sd_cmd_engine_if.slave   host,
  output logic             CMD_PIN_OUT,
  input  logic             CMD_PIN_IN,
  output logic             io_enable_cmd
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, CHECK, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       idx_q;
  logic [1:0]       rtype_q;
  logic [39:0]      tx_sr;
  logic [6:0]       crc;
  logic [7:0]       bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [127:0]     rx_sr;

  logic       tick;
  logic       long_resp;
  logic [7:0] rx_last;
  logic       crc_en;

  assign tick      = (div_cnt == clk_div);
  assign long_resp = (rtype_q == 2'b10);
  assign rx_last   = long_resp ? 8'd135 : 8'd47;
  // bit_cnt in RECV is the position after the start bit of the bit being sampled
  assign crc_en    = long_resp ? (bit_cnt >= 8'd8 && bit_cnt <= 8'd127) : (bit_cnt <= 8'd39);

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge clk_host or posedge reset_host) begin
    if (reset_host) begin
      state                  <= IDLE;
      div_cnt                <= '0;
      idx_q                  <= '0;
      rtype_q                <= '0;
      tx_sr                  <= '0;
      crc                    <= '0;
      bit_cnt                <= '0;
      to_cnt                 <= '0;
      rx_sr                  <= '0;
      host.cmd_busy          <= 1'b0;
      host.cmd_complete      <= 1'b0;
      host.cmd_index_error   <= 1'b0;
      host.cmd_crc_error     <= 1'b0;
      host.cmd_timeout_error <= 1'b0;
      host.response          <= '0;
      CMD_PIN_OUT            <= 1'b1;
      io_enable_cmd          <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (host.new_command) begin
            idx_q                  <= host.cmd_index;
            rtype_q                <= host.resp_type;
            tx_sr                  <= {2'b01, host.cmd_index, host.cmd_argument};
            crc                    <= '0;
            bit_cnt                <= '0;
            to_cnt                 <= '0;
            host.cmd_index_error   <= 1'b0;
            host.cmd_crc_error     <= 1'b0;
            host.cmd_timeout_error <= 1'b0;
            host.cmd_busy          <= 1'b1;
            div_cnt                <= '0;
            state                  <= SEND;
          end
        end
        SEND: begin
          if (tick) begin
            if (bit_cnt == 8'd48) begin
              io_enable_cmd <= 1'b0;
              CMD_PIN_OUT   <= 1'b1;
              bit_cnt       <= '0;
              if (rtype_q == 2'b00) begin
                host.cmd_complete <= 1'b1;
                host.cmd_busy     <= 1'b0;
                state             <= DONE;
              end else begin
                state <= WAIT_START;
              end
            end else begin
              io_enable_cmd <= 1'b1;
              bit_cnt       <= bit_cnt + 8'd1;
              if (bit_cnt < 8'd40) begin
                CMD_PIN_OUT <= tx_sr[39];
                tx_sr       <= {tx_sr[38:0], 1'b0};
                crc         <= crc7_next(crc, tx_sr[39]);
              end else if (bit_cnt < 8'd47) begin
                CMD_PIN_OUT <= crc[6];
                crc         <= {crc[5:0], 1'b0};
              end else begin
                CMD_PIN_OUT <= 1'b1;
              end
            end
          end
        end
        WAIT_START: begin
          if (tick) begin
            if (!CMD_PIN_IN) begin
              rx_sr   <= '0;
              crc     <= '0;
              bit_cnt <= 8'd1;
              state   <= RECV;
            end else if (to_cnt == TO_W'(TIMEOUT_BITS - 1)) begin
              host.cmd_timeout_error <= 1'b1;
              host.cmd_complete      <= 1'b1;
              host.cmd_busy          <= 1'b0;
              state                  <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (tick) begin
            rx_sr   <= {rx_sr[126:0], CMD_PIN_IN};
            bit_cnt <= bit_cnt + 8'd1;
            if (crc_en) crc <= crc7_next(crc, CMD_PIN_IN);
            if (bit_cnt == rx_last) state <= CHECK;
          end
        end
        CHECK: begin
          // rx_sr[0] is the end bit, CRC field sits in rx_sr[7:1] for both lengths
          if (long_resp) begin
            host.response      <= rx_sr;
            host.cmd_crc_error <= (crc != rx_sr[7:1]);
          end else begin
            host.response        <= {96'b0, rx_sr[39:8]};
            host.cmd_index_error <= (rtype_q == 2'b01) && (rx_sr[45:40] != idx_q);
            host.cmd_crc_error   <= (rtype_q == 2'b01) && (crc != rx_sr[7:1]);
          end
          host.cmd_complete <= 1'b1;
          host.cmd_busy     <= 1'b0;
          state             <= DONE;
        end
        DONE: begin
          host.cmd_complete <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - directed self-checking bench for sd_cmd_engine
module tb_sd_cmd_engine;
  logic       clk_host = 1'b0;
  logic       reset_host = 1'b1;
  logic [7:0] clk_div = 8'd0;
  logic       CMD_PIN_OUT;
  logic       CMD_PIN_IN = 1'b1;
  logic       io_enable_cmd;

  int compared = 0;
  int mismatched = 0;

  sd_cmd_engine_if host ();

  sd_cmd_engine #(.DIV_W(8), .TIMEOUT_BITS(64), .TO_W(7)) dut (
    .clk_host      (clk_host),
    .reset_host    (reset_host),
    .clk_div       (clk_div),
    .host          (host),
    .CMD_PIN_OUT   (CMD_PIN_OUT),
    .CMD_PIN_IN    (CMD_PIN_IN),
    .io_enable_cmd (io_enable_cmd)
  );

  always #5 clk_host = ~clk_host;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] v, input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Issues one command, captures the 48 wire bits at each tick, plays back an optional card reply
  // (two idle ticks, then reply MSB first) and returns the cycle of cmd_complete counted from accept.
  task automatic do_cmd(input int d, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [1:0] rt, input logic [135:0] reply, input int rbits,
                        output logic [47:0] sent, output int io_hi, output logic rel_ok,
                        output logic busy_ok, output int cyc);
    @(posedge clk_host);
    clk_div = 8'(d);
    @(negedge clk_host);
    host.cmd_index    = idx;
    host.cmd_argument = arg;
    host.resp_type    = rt;
    host.new_command  = 1'b1;
    @(posedge clk_host);
    #1 host.new_command = 1'b0;
    busy_ok = host.cmd_busy;
    sent = '0;
    io_hi = 0;
    for (int k = 0; k < 48; k++) begin
      repeat (d + 1) @(posedge clk_host);
      #1;
      sent = {sent[46:0], CMD_PIN_OUT};
      if (io_enable_cmd) io_hi++;
    end
    repeat (d + 1) @(posedge clk_host);
    #1;
    rel_ok = !io_enable_cmd && CMD_PIN_OUT;
    cyc = 49 * (d + 1);
    if (rbits > 0) begin
      for (int k = -2; k < rbits; k++) begin
        CMD_PIN_IN = (k < 0) ? 1'b1 : reply[rbits-1-k];
        repeat (d + 1) @(posedge clk_host);
        #1;
        cyc += d + 1;
      end
      CMD_PIN_IN = 1'b1;
    end
    while (!host.cmd_complete && cyc < 3000) begin
      @(posedge clk_host);
      #1;
      cyc++;
    end
    if (!host.cmd_complete) cyc = -1;
  endtask

  function automatic logic [2:0] flags();
    return {host.cmd_timeout_error, host.cmd_crc_error, host.cmd_index_error};
  endfunction

  initial begin
    logic [47:0]  sent;
    int           io_hi;
    logic         rel_ok;
    logic         busy_ok;
    int           cyc;
    logic [39:0]  r1;
    logic [47:0]  r1_frame;
    logic [119:0] cid;
    logic [135:0] r2_good;
    logic [135:0] r2_bad;

    host.new_command  = 1'b0;
    host.cmd_index    = '0;
    host.cmd_argument = '0;
    host.resp_type    = '0;
    repeat (3) @(posedge clk_host);
    #1;
    check("rst_busy", host.cmd_busy, 1'b0);
    check("rst_complete", host.cmd_complete, 1'b0);
    check("rst_flags", flags(), 3'b000);
    check("rst_response", host.response, 128'h0);
    check("rst_pin_out", CMD_PIN_OUT, 1'b1);
    check("rst_io_enable", io_enable_cmd, 1'b0);
    @(negedge clk_host);
    reset_host = 1'b0;

    // CMD0, no response, divider 0
    do_cmd(0, 6'd0, 32'h0, 2'b00, '0, 0, sent, io_hi, rel_ok, busy_ok, cyc);
    check("cmd0_wire", sent, 48'h400000000095);
    check("cmd0_io_hi", io_hi, 48);
    check("cmd0_release", rel_ok, 1'b1);
    check("cmd0_busy_after_accept", busy_ok, 1'b1);
    check("cmd0_complete_cycle", cyc, 49);
    check("cmd0_busy_at_complete", host.cmd_busy, 1'b0);
    check("cmd0_flags", flags(), 3'b000);
    @(posedge clk_host);
    #1;
    check("cmd0_complete_one_cycle", host.cmd_complete, 1'b0);

    // CMD8, divider 3, card echoes the check pattern
    do_cmd(3, 6'd8, 32'h000001AA, 2'b01, 136'h48000001AA87, 48, sent, io_hi, rel_ok, busy_ok, cyc);
    check("cmd8_wire", sent, 48'h48000001AA87);
    check("cmd8_io_hi", io_hi, 48);
    check("cmd8_complete_cycle", cyc, 397);
    check("cmd8_response", host.response, 128'h000001AA);
    check("cmd8_flags", flags(), 3'b000);

    // CMD17, card answers with index 18 and a valid CRC
    r1 = {2'b00, 6'd18, 32'h00000900};
    r1_frame = {r1, crc7({80'b0, r1}, 40), 1'b1};
    do_cmd(1, 6'd17, 32'h0, 2'b01, {88'b0, r1_frame}, 48, sent, io_hi, rel_ok, busy_ok, cyc);
    check("cmd17_wire", sent, 48'h510000000055);
    check("cmd17_flags", flags(), 3'b001);
    check("cmd17_response", host.response, 128'h00000900);

    // CMD2 with a clean 136-bit CID reply
    cid = 120'h035344534438474210DEADBEEF0101;
    r2_good = {2'b00, 6'b111111, cid, crc7(cid, 120), 1'b1};
    r2_bad = r2_good ^ (136'b1 << 60);
    do_cmd(0, 6'd2, 32'h0, 2'b10, r2_good, 136, sent, io_hi, rel_ok, busy_ok, cyc);
    check("cmd2_wire", sent, 48'h42000000004D);
    check("cmd2_complete_cycle", cyc, 188);
    check("cmd2_good_flags", flags(), 3'b000);
    check("cmd2_good_response", host.response, r2_good[127:0]);

    // CMD2 again with one payload bit flipped
    do_cmd(0, 6'd2, 32'h0, 2'b10, r2_bad, 136, sent, io_hi, rel_ok, busy_ok, cyc);
    check("cmd2_bad_flags", flags(), 3'b010);
    check("cmd2_bad_response", host.response, r2_bad[127:0]);

    // CMD13 with the card silent: timeout 64 ticks after release
    do_cmd(0, 6'd13, 32'h00010000, 2'b01, '0, 0, sent, io_hi, rel_ok, busy_ok, cyc);
    check("timeout_complete_cycle", cyc, 113);
    check("timeout_flags", flags(), 3'b100);
    check("timeout_response_held", host.response, r2_bad[127:0]);

    // Reset in the middle of a command frame
    @(posedge clk_host);
    @(negedge clk_host);
    host.cmd_index    = 6'd17;
    host.cmd_argument = 32'h0;
    host.resp_type    = 2'b01;
    host.new_command  = 1'b1;
    @(posedge clk_host);
    #1 host.new_command = 1'b0;
    repeat (10) @(posedge clk_host);
    #1;
    check("midsend_io_enable_before", io_enable_cmd, 1'b1);
    #2 reset_host = 1'b1;
    #1;
    check("midsend_io_enable", io_enable_cmd, 1'b0);
    check("midsend_pin_out", CMD_PIN_OUT, 1'b1);
    check("midsend_busy", host.cmd_busy, 1'b0);
    check("midsend_flags", flags(), 3'b000);
    @(negedge clk_host);
    reset_host = 1'b0;
    do_cmd(0, 6'd0, 32'h0, 2'b00, '0, 0, sent, io_hi, rel_ok, busy_ok, cyc);
    check("post_reset_wire", sent, 48'h400000000095);
    check("post_reset_complete_cycle", cyc, 49);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
